l15_resp_buffer: RTL and testbench
==================================

Name: l15_resp_buffer

Overview:
- Sits directly downstream of the L1.5 response port, between L1.5 and the core-side transducer.
- Accepts each L1.5 return (val / req_ack handshake) into a small FIFO, then presents it to the core with a valid/ready handshake.
- Decouples core back-pressure from L1.5 response timing.
- Entry width scales with the L1D line size.

Parameters:
- L15_L1D_LINE_SIZE, 64, L1D line size in bytes; sets data width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, derived, L1_MAX_DATA_PACKETS_BITS_WIDTH formula: (`L1I_LINE_SIZE < L15_L1D_LINE_SIZE) ? (L15_L1D_LINE_SIZE/`NOC_BYTES_WIDTH)*`NOC_BITS_WIDTH : 4*`NOC_BITS_WIDTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- l15_transducer_val  in  1  L1.5 return valid; held until acked.
- l15_transducer_returntype  in  4  return type.
- l15_transducer_threadid  in  `L15_THREADID_WIDTH  thread id.
- l15_transducer_noncacheable  in  1  NC flag.
- l15_transducer_error  in  2  error code.
- l15_transducer_address  in  `L15_PADDR_WIDTH  return address.
- l15_transducer_data  in  DATA_W  return data.
- transducer_l15_req_ack  out  1  accept pulse to L1.5.
- resp_val  out  1  head entry valid.
- resp_rdy  in  1  core consumes head.
- resp_returntype / resp_threadid / resp_noncacheable / resp_error / resp_address / resp_data  out  same widths as inputs  head entry fields.
- resp_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0; resp_val=0, transducer_l15_req_ack=0, resp_count=0. Data outputs are don't-care while resp_val=0; RTL drives the storage contents (no reset of storage required).
- transducer_l15_req_ack is combinational: l15_transducer_val && !full.
- Push occurs when req_ack=1: all input fields written at wr_ptr, wr_ptr increments. The L1.5 drops val the cycle after ack, so one push per ack.
- Pop occurs when resp_val && resp_rdy: rd_ptr increments.
- resp_val = (count != 0). Head fields come from the register array at rd_ptr (mux from registers, no output flop).
- Latency: a pushed entry is visible on resp_val the next cycle. There is no same-cycle bypass when empty.
- Full (count==DEPTH): req_ack=0 even if a pop occurs the same cycle (no full-bypass); accepted one cycle later.
- Empty: resp_val=0; resp_rdy ignored.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count is tracked separately, width $clog2(DEPTH)+1.
- resp_rdy asserted while resp_val=0: no effect. resp_val may not drop while the head is unconsumed.
- Reset mid-operation: all queued entries are discarded and outputs return to reset values immediately. A pending L1.5 val is re-acked after release.

Optional Feature:
- Macro L15_RESP_INVAL_FILTER_EN.
- Defined: returns with returntype == RET_INV (4'b0011, invalidation) are acked under the same full rule but not enqueued. A 16-bit saturating counter inval_drop_cnt (extra output port, reset 0) increments per dropped return.
- Undefined: all returntypes are enqueued; no counter or port exists.

Decomposition:
- Package l15_resp_pkg:
  - returntype constants (RET_LOAD=4'b0000, RET_IFILL=4'b0001, RET_INV=4'b0011, RET_ST_ACK=4'b0100).
  - resp_entry_t struct (returntype, threadid, nc, error, address, data).
  - DATA_W helper function.
- One sub-module l15_resp_fifo: generic register-array FIFO (push, pop, full, empty, count) instantiated with resp_entry_t width. l15_resp_buffer adds the handshake, filter and field unpacking.

Test Plan:
- Single return: val with returntype=4'b0000, data=0xDEADBEEF..., resp_rdy=1 → req_ack same cycle; next cycle resp_val=1 with matching fields; popped, resp_count back to 0.
- Fill: resp_rdy=0, 5 back-to-back vals (DEPTH=4) → 4 acks, resp_count=4, 5th val held with req_ack=0. Raise resp_rdy → 5th acked one cycle after first pop; order preserved (threadids 0,1,0,1,0).
- Full + pop same cycle: count=4, val high, resp_rdy=1 → no ack that cycle, count=3, then ack next cycle, count=4.
- Wrap-around: 10 push/pop pairs at steady state → pointers wrap; addresses 0x100..0x109 emerge in order, count never exceeds 1.
- Reset mid-run: count=3, assert rst_n=0 asynchronously → resp_val, req_ack, resp_count=0 before the next clock edge; post-release a held val is re-acked.
- Macro defined: returntype=4'b0011 return → acked, resp_val stays 0, inval_drop_cnt=1; a following load return is queued normally.

Source files
------------

// File: rtl/l15_resp_pkg.sv
// l15_resp_pkg: shared types and constants for the L1.5 response buffer.
// Supplies default widths for the OpenPiton-style macros when the
// surrounding build does not define them.

`ifndef L15_THREADID_WIDTH
`define L15_THREADID_WIDTH 1
`endif
`ifndef L15_PADDR_WIDTH
`define L15_PADDR_WIDTH 40
`endif
`ifndef NOC_BITS_WIDTH
`define NOC_BITS_WIDTH 64
`endif
`ifndef NOC_BYTES_WIDTH
`define NOC_BYTES_WIDTH 8
`endif
`ifndef L1I_LINE_SIZE
`define L1I_LINE_SIZE 32
`endif

package l15_resp_pkg;

   // L1.5 return type encodings
   localparam logic [3:0] RET_LOAD   = 4'b0000;
   localparam logic [3:0] RET_IFILL  = 4'b0001;
   localparam logic [3:0] RET_INV    = 4'b0011;
   localparam logic [3:0] RET_ST_ACK = 4'b0100;

   localparam int THREADID_W = `L15_THREADID_WIDTH;
   localparam int PADDR_W    = `L15_PADDR_WIDTH;

   // Data payload width: enough NoC flits to carry the larger of the
   // L1D line and four flits (the instruction-fill case).
   function automatic int calc_data_w(input int l1d_line_size);
      if (`L1I_LINE_SIZE < l1d_line_size)
         return (l1d_line_size / `NOC_BYTES_WIDTH) * `NOC_BITS_WIDTH;
      else
         return 4 * `NOC_BITS_WIDTH;
   endfunction

   localparam int DEFAULT_DATA_W = calc_data_w(64);

   // Control/address part of a return; the data payload is appended by
   // the buffer because its width depends on the instance parameter.
   typedef struct packed {
      logic [3:0]            returntype;
      logic [THREADID_W-1:0] threadid;
      logic                  nc;
      logic [1:0]            error;
      logic [PADDR_W-1:0]    address;
   } resp_hdr_t;

   localparam int HDR_W = $bits(resp_hdr_t);

   // Full entry for the default 64-byte L1D line configuration
   typedef struct packed {
      logic [3:0]                returntype;
      logic [THREADID_W-1:0]     threadid;
      logic                      nc;
      logic [1:0]                error;
      logic [PADDR_W-1:0]        address;
      logic [DEFAULT_DATA_W-1:0] data;
   } resp_entry_t;

endpackage

// File: rtl/l15_resp_fifo.sv
// l15_resp_fifo: generic register-array FIFO with separate occupancy count.
// Pointers wrap modulo DEPTH (power of two); the caller must not push when
// full nor pop when empty. Read data is a plain mux from the array.

module l15_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage is not reset; contents are only observed when count != 0
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Status flags and head read
   always_comb begin
      full  = (count == CNT_W'(DEPTH));
      empty = (count == '0);
      rdata = mem[rd_ptr];
   end

endmodule

// File: rtl/l15_resp_buffer.sv
// l15_resp_buffer: decouples L1.5 return timing from core back-pressure.
// Optional macro L15_RESP_INVAL_FILTER_EN: invalidation returns are acked
// but dropped, and counted in inval_drop_cnt.
//
// Handshakes:
//   L1.5 side: val is held until req_ack; req_ack = val && !full, with no
//   bypass when full (a pop in the same cycle frees space only for the
//   next cycle). Each ack is exactly one accepted return.
//   Core side: resp_val/resp_rdy, transfer when both high; resp_val stays
//   high until the head is consumed, and resp_rdy is ignored while empty.

module l15_resp_buffer
   import l15_resp_pkg::*;
#(
   parameter int L15_L1D_LINE_SIZE = 64,
   parameter int DEPTH = 4,
   localparam int DATA_W = calc_data_w(L15_L1D_LINE_SIZE),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           l15_transducer_val,
   input  logic [3:0]                     l15_transducer_returntype,
   input  logic [`L15_THREADID_WIDTH-1:0] l15_transducer_threadid,
   input  logic                           l15_transducer_noncacheable,
   input  logic [1:0]                     l15_transducer_error,
   input  logic [`L15_PADDR_WIDTH-1:0]    l15_transducer_address,
   input  logic [DATA_W-1:0]              l15_transducer_data,
   output logic                           transducer_l15_req_ack,
   output logic                           resp_val,
   input  logic                           resp_rdy,
   output logic [3:0]                     resp_returntype,
   output logic [`L15_THREADID_WIDTH-1:0] resp_threadid,
   output logic                           resp_noncacheable,
   output logic [1:0]                     resp_error,
   output logic [`L15_PADDR_WIDTH-1:0]    resp_address,
   output logic [DATA_W-1:0]              resp_data,
   output logic [CNT_W-1:0]               resp_count
`ifdef L15_RESP_INVAL_FILTER_EN
   ,
   output logic [15:0]                    inval_drop_cnt
`endif
);

   localparam int ENTRY_W = HDR_W + DATA_W;

   resp_hdr_t          in_hdr;
   resp_hdr_t          head_hdr;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] rd_entry;
   logic               fifo_full;
   logic               fifo_empty;
   logic               ack;
   logic               push;
   logic               pop;

   // Pack incoming return fields into one FIFO entry
   always_comb begin
      in_hdr.returntype = l15_transducer_returntype;
      in_hdr.threadid   = l15_transducer_threadid;
      in_hdr.nc         = l15_transducer_noncacheable;
      in_hdr.error      = l15_transducer_error;
      in_hdr.address    = l15_transducer_address;
      wr_entry          = {in_hdr, l15_transducer_data};
   end

   // Accept whenever there is room; held off while in reset so a val that
   // is up across reset is acked only after release
   assign ack = rst_n & l15_transducer_val & ~fifo_full;
   assign transducer_l15_req_ack = ack;

`ifdef L15_RESP_INVAL_FILTER_EN
   logic is_inv;
   assign is_inv = (l15_transducer_returntype == RET_INV);
   assign push   = ack & ~is_inv;

   // Saturating count of invalidations swallowed by the filter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         inval_drop_cnt <= '0;
      else if (ack && is_inv && (inval_drop_cnt != 16'hFFFF))
         inval_drop_cnt <= inval_drop_cnt + 16'd1;
   end
`else
   assign push = ack;
`endif

   // Core-side transfer; resp_val only when something is queued
   assign resp_val = ~fifo_empty;
   assign pop      = resp_val & resp_rdy;

   l15_resp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (rd_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (resp_count)
   );

   // Unpack head entry onto the core-side fields
   always_comb begin
      head_hdr          = rd_entry[ENTRY_W-1:DATA_W];
      resp_data         = rd_entry[DATA_W-1:0];
      resp_returntype   = head_hdr.returntype;
      resp_threadid     = head_hdr.threadid;
      resp_noncacheable = head_hdr.nc;
      resp_error        = head_hdr.error;
      resp_address      = head_hdr.address;
   end

endmodule

// File: tb/tb_l15_resp_buffer.sv
// tb_l15_resp_buffer: directed self-checking bench for l15_resp_buffer.
// Build with L15_RESP_INVAL_FILTER_EN defined to cover the filter.

`ifndef L15_THREADID_WIDTH
`define L15_THREADID_WIDTH 1
`endif
`ifndef L15_PADDR_WIDTH
`define L15_PADDR_WIDTH 40
`endif
`ifndef NOC_BITS_WIDTH
`define NOC_BITS_WIDTH 64
`endif
`ifndef NOC_BYTES_WIDTH
`define NOC_BYTES_WIDTH 8
`endif
`ifndef L1I_LINE_SIZE
`define L1I_LINE_SIZE 32
`endif

module tb_l15_resp_buffer;

   localparam int LINE   = 64;
   localparam int DEPTH  = 4;
   localparam int DATA_W = (`L1I_LINE_SIZE < LINE) ? (LINE / `NOC_BYTES_WIDTH) * `NOC_BITS_WIDTH
                                                    : 4 * `NOC_BITS_WIDTH;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int TID_W  = `L15_THREADID_WIDTH;
   localparam int ADDR_W = `L15_PADDR_WIDTH;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              val = 1'b0;
   logic [3:0]        rt = '0;
   logic [TID_W-1:0]  tid = '0;
   logic              nc = 1'b0;
   logic [1:0]        err = '0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] data = '0;
   logic              rdy = 1'b0;

   logic              ack;
   logic              resp_val;
   logic [3:0]        resp_rt;
   logic [TID_W-1:0]  resp_tid;
   logic              resp_nc;
   logic [1:0]        resp_err;
   logic [ADDR_W-1:0] resp_addr;
   logic [DATA_W-1:0] resp_data;
   logic [CNT_W-1:0]  resp_count;
`ifdef L15_RESP_INVAL_FILTER_EN
   logic [15:0]       inval_drop_cnt;
`endif

   int total = 0;
   int bad = 0;

   l15_resp_buffer #(.L15_L1D_LINE_SIZE(LINE), .DEPTH(DEPTH)) dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .l15_transducer_val          (val),
      .l15_transducer_returntype   (rt),
      .l15_transducer_threadid     (tid),
      .l15_transducer_noncacheable (nc),
      .l15_transducer_error        (err),
      .l15_transducer_address      (addr),
      .l15_transducer_data         (data),
      .transducer_l15_req_ack      (ack),
      .resp_val                    (resp_val),
      .resp_rdy                    (rdy),
      .resp_returntype             (resp_rt),
      .resp_threadid               (resp_tid),
      .resp_noncacheable           (resp_nc),
      .resp_error                  (resp_err),
      .resp_address                (resp_addr),
      .resp_data                   (resp_data),
      .resp_count                  (resp_count)
`ifdef L15_RESP_INVAL_FILTER_EN
      ,
      .inval_drop_cnt              (inval_drop_cnt)
`endif
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   // advance one clock, land 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL reset_val got=%0h exp=0", resp_val); end
      total++; if (resp_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", resp_count); end
      val = 1'b1;
      #1;
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0h exp=0", ack); end
      val = 1'b0;
      rst_n = 1'b1;
      step();
      total++; if (resp_count !== '0) begin bad++; $display("FAIL reset_release_count got=%0d exp=0", resp_count); end
   endtask

   task automatic test_single();
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = 40'h12_3456_7880;
      d = {16{32'hDEADBEEF}};
      rdy = 1'b1; val = 1'b1; rt = 4'b0000; tid = 1'b1; nc = 1'b1; err = 2'd2;
      addr = a; data = d;
      #1;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL single_ack got=%0h exp=1", ack); end
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%0h exp=0", resp_val); end
      step();
      val = 1'b0; data = '0; addr = '0; tid = '0; nc = 1'b0; err = '0;
      #1;
      total++; if (resp_val !== 1'b1) begin bad++; $display("FAIL single_val got=%0h exp=1", resp_val); end
      total++; if (resp_count !== CNT_W'(1)) begin bad++; $display("FAIL single_count got=%0d exp=1", resp_count); end
      total++; if (resp_rt !== 4'b0000) begin bad++; $display("FAIL single_rt got=%0h exp=0", resp_rt); end
      total++; if (resp_tid !== TID_W'(1)) begin bad++; $display("FAIL single_tid got=%0h exp=1", resp_tid); end
      total++; if (resp_nc !== 1'b1) begin bad++; $display("FAIL single_nc got=%0h exp=1", resp_nc); end
      total++; if (resp_err !== 2'd2) begin bad++; $display("FAIL single_err got=%0h exp=2", resp_err); end
      total++; if (resp_addr !== a) begin bad++; $display("FAIL single_addr got=%0h exp=%0h", resp_addr, a); end
      total++; if (resp_data !== d) begin bad++; $display("FAIL single_data got=%0h exp=%0h", resp_data, d); end
      step();
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL single_pop_val got=%0h exp=0", resp_val); end
      total++; if (resp_count !== '0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", resp_count); end
      rdy = 1'b0;
   endtask

   // fill to full, hold the 5th, then a single-cycle pop (full + pop same cycle)
   task automatic test_fill_full_pop();
      rdy = 1'b0; rt = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         val = 1'b1; tid = TID_W'(i % 2); addr = ADDR_W'(32'h200 + i); data = DATA_W'(i);
         #1;
         total++; if (ack !== 1'b1) begin bad++; $display("FAIL fill_ack%0d got=%0h exp=1", i, ack); end
         step();
      end
      tid = '0; addr = ADDR_W'(32'h204); data = DATA_W'(4);
      #1;
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL fill_full_ack got=%0h exp=0", ack); end
      total++; if (resp_count !== CNT_W'(4)) begin bad++; $display("FAIL fill_count got=%0d exp=4", resp_count); end
      step();
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL fill_hold_ack got=%0h exp=0", ack); end
      rdy = 1'b1;
      #1;
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL full_pop_no_bypass got=%0h exp=0", ack); end
      total++; if (resp_addr !== ADDR_W'(32'h200)) begin bad++; $display("FAIL full_head0 got=%0h exp=200", resp_addr); end
      step();
      rdy = 1'b0;
      #1;
      total++; if (resp_count !== CNT_W'(3)) begin bad++; $display("FAIL full_pop_count got=%0d exp=3", resp_count); end
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL full_late_ack got=%0h exp=1", ack); end
      step();
      val = 1'b0;
      #1;
      total++; if (resp_count !== CNT_W'(4)) begin bad++; $display("FAIL full_refill_count got=%0d exp=4", resp_count); end
      rdy = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         total++; if (resp_addr !== ADDR_W'(32'h200 + k)) begin bad++; $display("FAIL drain_addr%0d got=%0h exp=%0h", k, resp_addr, 32'h200 + k); end
         total++; if (resp_tid !== TID_W'(k % 2)) begin bad++; $display("FAIL drain_tid%0d got=%0h exp=%0h", k, resp_tid, k % 2); end
         total++; if (resp_data !== DATA_W'(k)) begin bad++; $display("FAIL drain_data%0d got=%0h exp=%0h", k, resp_data, k); end
         step();
      end
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0h exp=0", resp_val); end
      total++; if (resp_count !== '0) begin bad++; $display("FAIL drain_count got=%0d exp=0", resp_count); end
      rdy = 1'b0;
   endtask

   // steady push/pop pairs, pointers wrap several times
   task automatic test_wrap();
      rdy = 1'b1; rt = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         val = 1'b1; addr = ADDR_W'(32'h100 + i); data = DATA_W'(32'hA0 + i);
         #1;
         total++; if (ack !== 1'b1) begin bad++; $display("FAIL wrap_ack%0d got=%0h exp=1", i, ack); end
         if (i > 0) begin
            total++; if (resp_addr !== ADDR_W'(32'h100 + i - 1)) begin bad++; $display("FAIL wrap_addr%0d got=%0h exp=%0h", i, resp_addr, 32'h100 + i - 1); end
            total++; if (resp_count !== CNT_W'(1)) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=1", i, resp_count); end
         end
         step();
      end
      val = 1'b0;
      #1;
      total++; if (resp_addr !== ADDR_W'(32'h109)) begin bad++; $display("FAIL wrap_last got=%0h exp=109", resp_addr); end
      total++; if (resp_rt !== 4'b0001) begin bad++; $display("FAIL wrap_rt got=%0h exp=1", resp_rt); end
      step();
      total++; if (resp_count !== '0) begin bad++; $display("FAIL wrap_end_count got=%0d exp=0", resp_count); end
      rdy = 1'b0;
   endtask

   // asynchronous reset with 3 queued entries and a val pending
   task automatic test_reset_mid();
      rdy = 1'b0; rt = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         val = 1'b1; addr = ADDR_W'(32'h30 + i);
         step();
      end
      addr = ADDR_W'(32'h300);
      #1;
      total++; if (resp_count !== CNT_W'(3)) begin bad++; $display("FAIL mid_count got=%0d exp=3", resp_count); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL mid_rst_val got=%0h exp=0", resp_val); end
      total++; if (ack !== 1'b0) begin bad++; $display("FAIL mid_rst_ack got=%0h exp=0", ack); end
      total++; if (resp_count !== '0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", resp_count); end
      step();
      rst_n = 1'b1;
      #1;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL mid_reack got=%0h exp=1", ack); end
      step();
      val = 1'b0;
      #1;
      total++; if (resp_count !== CNT_W'(1)) begin bad++; $display("FAIL mid_post_count got=%0d exp=1", resp_count); end
      total++; if (resp_addr !== ADDR_W'(32'h300)) begin bad++; $display("FAIL mid_post_addr got=%0h exp=300", resp_addr); end
      rdy = 1'b1;
      step();
      total++; if (resp_count !== '0) begin bad++; $display("FAIL mid_drain got=%0d exp=0", resp_count); end
      rdy = 1'b0;
   endtask

`ifdef L15_RESP_INVAL_FILTER_EN
   task automatic test_inval_filter();
      rdy = 1'b0;
      val = 1'b1; rt = 4'b0011; addr = ADDR_W'(32'h400);
      #1;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL inv_ack got=%0h exp=1", ack); end
      step();
      val = 1'b0;
      #1;
      total++; if (resp_val !== 1'b0) begin bad++; $display("FAIL inv_val got=%0h exp=0", resp_val); end
      total++; if (inval_drop_cnt !== 16'd1) begin bad++; $display("FAIL inv_cnt got=%0d exp=1", inval_drop_cnt); end
      val = 1'b1; rt = 4'b0000; addr = ADDR_W'(32'h500);
      step();
      val = 1'b0;
      #1;
      total++; if (resp_val !== 1'b1) begin bad++; $display("FAIL inv_load_val got=%0h exp=1", resp_val); end
      total++; if (resp_addr !== ADDR_W'(32'h500)) begin bad++; $display("FAIL inv_load_addr got=%0h exp=500", resp_addr); end
      total++; if (inval_drop_cnt !== 16'd1) begin bad++; $display("FAIL inv_cnt_hold got=%0d exp=1", inval_drop_cnt); end
      rdy = 1'b1;
      step();
      rdy = 1'b0;
   endtask
`else
   task automatic test_inv_passthrough();
      rdy = 1'b0;
      val = 1'b1; rt = 4'b0011; addr = ADDR_W'(32'h400);
      #1;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL inv_ack got=%0h exp=1", ack); end
      step();
      val = 1'b0;
      #1;
      total++; if (resp_val !== 1'b1) begin bad++; $display("FAIL inv_queued got=%0h exp=1", resp_val); end
      total++; if (resp_rt !== 4'b0011) begin bad++; $display("FAIL inv_rt got=%0h exp=3", resp_rt); end
      rdy = 1'b1;
      step();
      total++; if (resp_count !== '0) begin bad++; $display("FAIL inv_drain got=%0d exp=0", resp_count); end
      rdy = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill_full_pop();
      test_wrap();
      test_reset_mid();
`ifdef L15_RESP_INVAL_FILTER_EN
      test_inval_filter();
`else
      test_inv_passthrough();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
